idli_serial_ex_m: RTL

// - Parametrised bit-serial execute stage: runs one DATA_W-bit ALU op as BEATS = DATA_W/LANE_W
//   LSB-first lane beats, with the carry chained between beats.
// - Sits between decode (op_t + vld/acp handshake) and the register/memory lane datapath.
// - Adds to the fixed 4b/16b stage: width/lane generality, immediate-data stall, per-beat result

---
 rtl/idli_pkg.sv | 35 +++
 rtl/idli_lane_alu_m.sv | 47 ++++
 rtl/idli_serial_ex_m.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// Shared types and encodings for the idli serial datapath.
//   op_t    : decoded op handed from decode to the serial execute stage
//   flags_t : {c,z,n} condition flags produced at the end of an op
package idli_pkg;

  // ALU operation encodings.
  localparam logic [1:0] ALU_OP_ADD = 2'd0;
  localparam logic [1:0] ALU_OP_AND = 2'd1;
  localparam logic [1:0] ALU_OP_OR  = 2'd2;
  localparam logic [1:0] ALU_OP_XOR = 2'd3;

  // LHS operand source encodings (2'd3 is unused).
  localparam logic [1:0] LHS_SRC_REG  = 2'd0;
  localparam logic [1:0] LHS_SRC_ZERO = 2'd1;
  localparam logic [1:0] LHS_SRC_PC   = 2'd2;

  // RHS operand source encodings (2'd2 and 2'd3 are unused).
  localparam logic [1:0] RHS_SRC_REG = 2'd0;
  localparam logic [1:0] RHS_SRC_IMM = 2'd1;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_rhs_inv;
    logic       alu_cin;
    logic [1:0] lhs_src;
    logic [1:0] rhs_src;
  } op_t;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
  } flags_t;

endpackage

// File: rtl/idli_lane_alu_m.sv
// Combinational single-lane ALU used by the bit-serial execute stage.
//   op_i      : ALU_OP_* select
//   rhs_inv_i : invert rhs before the operation (subtract with cin=1)
//   lhs_i     : lhs lane
//   rhs_i     : rhs lane
//   cin_i     : carry into this lane
//   res_o     : result lane
//   cout_o    : carry out of this lane (ADD only, else 0)
module idli_lane_alu_m
  import idli_pkg::*;
#(
  parameter int unsigned LANE_W = 4
) (
  input  logic [1:0]        op_i,
  input  logic              rhs_inv_i,
  input  logic [LANE_W-1:0] lhs_i,
  input  logic [LANE_W-1:0] rhs_i,
  input  logic              cin_i,
  output logic [LANE_W-1:0] res_o,
  output logic              cout_o
);

  localparam int unsigned SUM_W = LANE_W + 1;

  logic [LANE_W-1:0] rhs_eff;
  logic [SUM_W-1:0]  sum;

  assign rhs_eff = rhs_inv_i ? ~rhs_i : rhs_i;
  assign sum     = {1'b0, lhs_i} + {1'b0, rhs_eff} + SUM_W'(cin_i);

  // Lane result and carry select.
  always_comb begin
    res_o  = '0;
    cout_o = 1'b0;
    case (op_i)
      ALU_OP_ADD: begin
        res_o  = sum[LANE_W-1:0];
        cout_o = sum[LANE_W];
      end
      ALU_OP_AND: res_o = lhs_i & rhs_eff;
      ALU_OP_OR:  res_o = lhs_i | rhs_eff;
      ALU_OP_XOR: res_o = lhs_i ^ rhs_eff;
      default:    res_o = '0;
    endcase
  end

endmodule

// File: rtl/idli_serial_ex_m.sv
// Bit-serial execute stage: runs one DATA_W-bit ALU op as DATA_W/LANE_W
// LSB-first lane beats, chaining the carry between beats.
//   i_sx_gck / i_sx_rst_n         : clock, async active-low reset
//   i_sx_op / i_sx_op_vld         : decoded op from decode
//   o_sx_op_acp                   : op taken this cycle (combinational)
//   i_sx_lhs/rhs/pc/imm           : operand lanes for the current beat
//   i_sx_imm_vld                  : immediate lane valid; stalls IMM ops when low
//   o_sx_beat                     : current beat index
//   o_sx_res / o_sx_res_vld       : result lane, valid when the beat completes (combinational)
//   o_sx_flags / o_sx_flags_vld   : {c,z,n} of the last op, pulse on update
module idli_serial_ex_m
  import idli_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANE_W = 4,
  localparam int unsigned BEATS = DATA_W / LANE_W,
  localparam int unsigned CTR_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              i_sx_gck,
  input  logic              i_sx_rst_n,
  input  op_t               i_sx_op,
  input  logic              i_sx_op_vld,
  output logic              o_sx_op_acp,
  input  logic [LANE_W-1:0] i_sx_lhs,
  input  logic [LANE_W-1:0] i_sx_rhs,
  input  logic [LANE_W-1:0] i_sx_pc,
  input  logic [LANE_W-1:0] i_sx_imm,
  input  logic              i_sx_imm_vld,
  output logic [CTR_W-1:0]  o_sx_beat,
  output logic [LANE_W-1:0] o_sx_res,
  output logic              o_sx_res_vld,
  output flags_t            o_sx_flags,
  output logic              o_sx_flags_vld
);

  // Reject geometries that cannot be run as at least two whole lanes.
  if ((LANE_W == 0) || ((DATA_W % LANE_W) != 0) || (BEATS < 2)) begin : g_param_err
    $error("idli_serial_ex_m: DATA_W must be a multiple of LANE_W with at least 2 beats");
  end

  localparam logic [CTR_W-1:0] LAST_BEAT = CTR_W'(BEATS - 1);

  op_t              op_q, op_d;
  logic             busy_q, busy_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  flags_t           flags_q, flags_d;
  logic             flags_vld_q, flags_vld_d;

  logic              adv;
  logic              last;
  logic              first;
  logic              cin;
  logic              cout;
  logic              zero_acc;
  logic [LANE_W-1:0] lhs;
  logic [LANE_W-1:0] rhs;
  logic [LANE_W-1:0] res;

  // A beat completes unless an IMM op is waiting on memory.
  assign adv   = busy_q && ((op_q.rhs_src != RHS_SRC_IMM) || i_sx_imm_vld);
  assign last  = adv && (ctr_q == LAST_BEAT);
  assign first = (ctr_q == '0);

  // Operand selection; unused encodings are don't-care.
  always_comb begin
    lhs = 'x;
    rhs = 'x;
    case (op_q.lhs_src)
      LHS_SRC_REG:  lhs = i_sx_lhs;
      LHS_SRC_ZERO: lhs = '0;
      LHS_SRC_PC:   lhs = i_sx_pc;
      default:      lhs = 'x;
    endcase
    case (op_q.rhs_src)
      RHS_SRC_REG: rhs = i_sx_rhs;
      RHS_SRC_IMM: rhs = i_sx_imm;
      default:     rhs = 'x;
    endcase
  end

  // Beat 0 takes the op's carry-in; later beats take the chained carry.
  assign cin = first ? op_q.alu_cin : carry_q;

  idli_lane_alu_m #(
    .LANE_W (LANE_W)
  ) u_lane_alu (
    .op_i      (op_q.alu_op),
    .rhs_inv_i (op_q.alu_rhs_inv),
    .lhs_i     (lhs),
    .rhs_i     (rhs),
    .cin_i     (cin),
    .res_o     (res),
    .cout_o    (cout)
  );

  // Zero accumulator reseeds on beat 0 so back-to-back ops need no clear cycle.
  assign zero_acc = (first | zero_q) & ~|res;

  // Next-state: handshake, beat counter, carry/zero chain and end-of-op flags.
  always_comb begin
    op_d        = op_q;
    busy_d      = busy_q;
    ctr_d       = ctr_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    flags_d     = flags_q;
    flags_vld_d = last;

    if (o_sx_op_acp) begin
      op_d   = i_sx_op;
      busy_d = i_sx_op_vld;
    end

    if (adv) begin
      ctr_d   = last ? '0 : ctr_q + CTR_W'(1);
      carry_d = cout;
      zero_d  = zero_acc;
    end

    if (last) begin
      flags_d.c = cout;
      flags_d.z = zero_acc;
      flags_d.n = res[LANE_W-1];
    end
  end

  // State registers.
  always_ff @(posedge i_sx_gck or negedge i_sx_rst_n) begin
    if (!i_sx_rst_n) begin
      op_q        <= '0;
      busy_q      <= 1'b0;
      ctr_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      flags_q     <= '0;
      flags_vld_q <= 1'b0;
    end else begin
      op_q        <= op_d;
      busy_q      <= busy_d;
      ctr_q       <= ctr_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      flags_q     <= flags_d;
      flags_vld_q <= flags_vld_d;
    end
  end

  assign o_sx_op_acp    = !busy_q || last;
  assign o_sx_beat      = ctr_q;
  assign o_sx_res       = res;
  assign o_sx_res_vld   = adv;
  assign o_sx_flags     = flags_q;
  assign o_sx_flags_vld = flags_vld_q;

endmodule
